// File: rtl/sram_sp_arbiter.sv
// Shares one single-port byte-enable SRAM (1-cycle read latency) between instruction and data buses.
// Grant is combinational with 0-cycle latency, and read data returns 1 cycle later. A losing port sees ready low and must hold its request.
module sram_sp_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int PRIO   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_avalid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_rvalid_o,
  output logic                i_ready_o,
  input  logic                d_avalid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_rvalid_o,
  output logic                d_ready_o,
  output logic                m_en_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W/8-1:0] m_we_o,
  output logic [DATA_W-1:0]   m_din_o,
  input  logic [DATA_W-1:0]   m_dout_i
);

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic last_grant;
  logic gnt_i;
  logic gnt_d;
  logic pend_i;
  logic pend_d;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (i_avalid_i && d_avalid_i) begin
      if (PRIO == 1) begin
        gnt_i = 1'b1;
      end else if (PRIO == 2) begin
        gnt_d = 1'b1;
      end else if (last_grant == GNT_D) begin
        gnt_i = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else begin
      gnt_i = i_avalid_i;
      gnt_d = d_avalid_i;
    end
  end

  // A port is only blocked when the other one owns the SRAM this cycle.
  assign i_ready_o = ~gnt_d;
  assign d_ready_o = ~gnt_i;

  assign m_en_o   = gnt_i | gnt_d;
  assign m_addr_o = gnt_d ? d_addr_i  : i_addr_i;
  assign m_din_o  = gnt_d ? d_wdata_i : i_wdata_i;
  assign m_we_o   = gnt_i ? i_wstrb_i : (gnt_d ? d_wstrb_i : '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= GNT_D;
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
    end else begin
      if (m_en_o) begin
        last_grant <= gnt_d ? GNT_D : GNT_I;
      end
      pend_i <= gnt_i & ~(|i_wstrb_i);
      pend_d <= gnt_d & ~(|d_wstrb_i);
    end
  end

  // The SRAM output is shared; the registered pending flag says whose data it is.
  assign i_rvalid_o = pend_i;
  assign d_rvalid_o = pend_d;
  assign i_rdata_o  = m_dout_i;
  assign d_rdata_o  = m_dout_i;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench: a round-robin and an instruction-priority arbiter, each driving its own SRAM model, share the same stimulus.
module tb_sram_sp_arbiter;

  logic        clk;
  logic        rst;
  logic        i_avalid, d_avalid;
  logic [12:0] i_addr, d_addr;
  logic [31:0] i_wdata, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;

  logic [31:0] i_rdata0, d_rdata0, m_din0, m_dout0;
  logic        i_rvalid0, d_rvalid0, i_ready0, d_ready0, m_en0;
  logic [12:0] m_addr0;
  logic [3:0]  m_we0;

  logic [31:0] i_rdata1, d_rdata1, m_din1, m_dout1;
  logic        i_rvalid1, d_rvalid1, i_ready1, d_ready1, m_en1;
  logic [12:0] m_addr1;
  logic [3:0]  m_we1;

  logic [31:0] mem0 [0:8191];
  logic [31:0] mem1 [0:8191];

  int n_cmp = 0;
  int n_err = 0;

  sram_sp_arbiter #(.DATA_W(32), .ADDR_W(13), .PRIO(0)) u0 (
    .clk_i(clk), .rst_i(rst),
    .i_avalid_i(i_avalid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
    .i_rdata_o(i_rdata0), .i_rvalid_o(i_rvalid0), .i_ready_o(i_ready0),
    .d_avalid_i(d_avalid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_rdata_o(d_rdata0), .d_rvalid_o(d_rvalid0), .d_ready_o(d_ready0),
    .m_en_o(m_en0), .m_addr_o(m_addr0), .m_we_o(m_we0), .m_din_o(m_din0), .m_dout_i(m_dout0)
  );

  sram_sp_arbiter #(.DATA_W(32), .ADDR_W(13), .PRIO(1)) u1 (
    .clk_i(clk), .rst_i(rst),
    .i_avalid_i(i_avalid), .i_addr_i(i_addr), .i_wdata_i(i_wdata), .i_wstrb_i(i_wstrb),
    .i_rdata_o(i_rdata1), .i_rvalid_o(i_rvalid1), .i_ready_o(i_ready1),
    .d_avalid_i(d_avalid), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_rdata_o(d_rdata1), .d_rvalid_o(d_rvalid1), .d_ready_o(d_ready1),
    .m_en_o(m_en1), .m_addr_o(m_addr1), .m_we_o(m_we1), .m_din_o(m_din1), .m_dout_i(m_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: preload a few words while reset is high, 1-cycle registered read.
  always @(posedge clk) begin
    if (rst) begin
      mem0[13'h010] <= 32'hDEADBEEF;
      mem0[13'h001] <= 32'h11111111;
      mem0[13'h002] <= 32'h22222222;
      mem0[13'h020] <= 32'h12345678;
    end else if (m_en0) begin
      for (int b = 0; b < 4; b++)
        if (m_we0[b]) mem0[m_addr0][8*b +: 8] <= m_din0[8*b +: 8];
      if (m_we0 == 4'b0000) m_dout0 <= mem0[m_addr0];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      mem1[13'h010] <= 32'hDEADBEEF;
      mem1[13'h001] <= 32'h11111111;
      mem1[13'h002] <= 32'h22222222;
      mem1[13'h020] <= 32'h12345678;
    end else if (m_en1) begin
      for (int b = 0; b < 4; b++)
        if (m_we1[b]) mem1[m_addr1][8*b +: 8] <= m_din1[8*b +: 8];
      if (m_we1 == 4'b0000) m_dout1 <= mem1[m_addr1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_avalid = 1'b0; i_addr = '0; i_wdata = '0; i_wstrb = '0;
    d_avalid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    step;
    step;
    chk("rst_i_rvalid0", {31'd0, i_rvalid0}, 32'd0);
    chk("rst_d_rvalid0", {31'd0, d_rvalid0}, 32'd0);
    chk("rst_i_rvalid1", {31'd0, i_rvalid1}, 32'd0);
    chk("rst_d_rvalid1", {31'd0, d_rvalid1}, 32'd0);
    rst = 1'b0;

    // Single instruction read.
    i_avalid = 1'b1; i_addr = 13'h010; i_wstrb = 4'b0000;
    #1;
    chk("t1_i_ready", {31'd0, i_ready0}, 32'd1);
    chk("t1_m_en", {31'd0, m_en0}, 32'd1);
    chk("t1_m_addr", {19'd0, m_addr0}, 32'h010);
    chk("t1_m_we", {28'd0, m_we0}, 32'd0);
    step;
    i_avalid = 1'b0;
    chk("t1_i_rvalid", {31'd0, i_rvalid0}, 32'd1);
    chk("t1_i_rdata", i_rdata0, 32'hDEADBEEF);
    chk("t1_d_rvalid", {31'd0, d_rvalid0}, 32'd0);
    step;
    chk("t1_i_rvalid_drop", {31'd0, i_rvalid0}, 32'd0);

    // Round-robin streaming from a fresh reset: I, D, I, D.
    rst = 1'b1;
    step;
    rst = 1'b0;
    i_avalid = 1'b1; i_addr = 13'h001;
    d_avalid = 1'b1; d_addr = 13'h002; d_wstrb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2_i_ready_%0d", k), {31'd0, i_ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_d_ready_%0d", k), {31'd0, d_ready0}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t2_m_addr_%0d", k), {19'd0, m_addr0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step;
      chk($sformatf("t2_i_rvalid_%0d", k), {31'd0, i_rvalid0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2_d_rvalid_%0d", k), {31'd0, d_rvalid0}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) chk($sformatf("t2_i_rdata_%0d", k), i_rdata0, 32'h11111111);
      else            chk($sformatf("t2_d_rdata_%0d", k), d_rdata0, 32'h22222222);
    end
    i_avalid = 1'b0;
    d_avalid = 1'b0;
    step;

    // Partial write then read-back on D.
    d_avalid = 1'b1; d_addr = 13'h020; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'b0011;
    #1;
    chk("t3_m_we", {28'd0, m_we0}, 32'h3);
    chk("t3_m_din", m_din0, 32'hA5A5A5A5);
    chk("t3_d_ready", {31'd0, d_ready0}, 32'd1);
    step;
    chk("t3_wr_no_rvalid", {31'd0, d_rvalid0}, 32'd0);
    d_wstrb = 4'b0000;
    #1;
    chk("t3_rd_m_we", {28'd0, m_we0}, 32'd0);
    step;
    d_avalid = 1'b0;
    chk("t3_d_rvalid", {31'd0, d_rvalid0}, 32'd1);
    chk("t3_d_rdata", d_rdata0, 32'h1234A5A5);
    step;
    chk("t3_d_rvalid_once", {31'd0, d_rvalid0}, 32'd0);

    // Instruction-priority instance: D starves until I drops.
    i_avalid = 1'b1; i_addr = 13'h001; i_wstrb = 4'b0000;
    d_avalid = 1'b1; d_addr = 13'h002; d_wstrb = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_i_ready_%0d", k), {31'd0, i_ready1}, 32'd1);
      chk($sformatf("t4_d_ready_%0d", k), {31'd0, d_ready1}, 32'd0);
      chk($sformatf("t4_m_addr_%0d", k), {19'd0, m_addr1}, 32'd1);
      step;
    end
    i_avalid = 1'b0;
    #1;
    chk("t4_d_ready_release", {31'd0, d_ready1}, 32'd1);
    chk("t4_m_addr_release", {19'd0, m_addr1}, 32'd2);
    step;
    d_avalid = 1'b0;
    chk("t4_d_rvalid", {31'd0, d_rvalid1}, 32'd1);
    chk("t4_d_rdata", d_rdata1, 32'h22222222);

    // Read granted while reset is high is discarded.
    i_avalid = 1'b1; i_addr = 13'h010;
    rst = 1'b1;
    step;
    rst = 1'b0;
    i_avalid = 1'b0;
    chk("t5_i_rvalid_after_rst", {31'd0, i_rvalid0}, 32'd0);
    chk("t5_d_rvalid_after_rst", {31'd0, d_rvalid0}, 32'd0);
    i_avalid = 1'b1; i_addr = 13'h001;
    d_avalid = 1'b1; d_addr = 13'h002;
    #1;
    chk("t5_i_ready_first", {31'd0, i_ready0}, 32'd1);
    chk("t5_d_ready_first", {31'd0, d_ready0}, 32'd0);
    chk("t5_m_addr_first", {19'd0, m_addr0}, 32'd1);
    step;
    i_avalid = 1'b0;
    #1;
    chk("t5_i_rvalid", {31'd0, i_rvalid0}, 32'd1);
    chk("t5_i_rdata", i_rdata0, 32'h11111111);
    chk("t5_d_ready_held", {31'd0, d_ready0}, 32'd1);
    step;
    d_avalid = 1'b0;
    chk("t5_d_rvalid", {31'd0, d_rvalid0}, 32'd1);
    chk("t5_d_rdata", d_rdata0, 32'h22222222);

    // Staggered reads: responses land in consecutive cycles, never together.
    i_avalid = 1'b1; i_addr = 13'h010;
    step;
    i_avalid = 1'b0;
    d_avalid = 1'b1; d_addr = 13'h020;
    chk("t6_i_rvalid_n1", {31'd0, i_rvalid0}, 32'd1);
    chk("t6_d_rvalid_n1", {31'd0, d_rvalid0}, 32'd0);
    chk("t6_i_rdata", i_rdata0, 32'hDEADBEEF);
    step;
    d_avalid = 1'b0;
    chk("t6_i_rvalid_n2", {31'd0, i_rvalid0}, 32'd0);
    chk("t6_d_rvalid_n2", {31'd0, d_rvalid0}, 32'd1);
    chk("t6_d_rdata", d_rdata0, 32'h12345678);
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Shares one single-port byte-enable SRAM macro (1-cycle read latency) between the CPU instruction bus and data bus.
- Lets the SoC build with a single-port main memory while keeping both native request/response bus ports unchanged.
- Arbitrates per cycle, round-robin or fixed priority. Tracks the in-flight read so each response returns to the correct requester.
- Sits between the CPU bus split and the SRAM macro instance.

Parameters:
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- ADDR_W, 13, word address width (SRAM_ADDR_W-2 at top level).
- PRIO, 0, 0 = round-robin; 1 = instruction port always wins; 2 = data port always wins.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: synchronous, active-high
- i_avalid_i  in  1  instruction request valid
- i_addr_i  in  ADDR_W  instruction word address
- i_wdata_i  in  DATA_W  instruction write data (boot load)
- i_wstrb_i  in  DATA_W/8  instruction byte strobes; 0 = read
- i_rdata_o  out  DATA_W  instruction read data
- i_rvalid_o  out  1  instruction read data valid
- i_ready_o  out  1  instruction request accepted this cycle
- d_avalid_i, d_addr_i, d_wdata_i, d_wstrb_i, d_rdata_o, d_rvalid_o, d_ready_o: same as the i_ ports, for the data bus
- m_en_o  out  1  SRAM enable
- m_addr_o  out  ADDR_W  SRAM address
- m_we_o  out  DATA_W/8  SRAM byte write enables
- m_din_o  out  DATA_W  SRAM write data
- m_dout_i  in  DATA_W  SRAM read data, valid 1 cycle after a read enable

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - i_rvalid_o=0, d_rvalid_o=0.
  - Pending-read registers cleared.
  - last_grant = D, so the instruction port wins the first round-robin conflict.
- Grant is combinational, same cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: PRIO=1 grants I; PRIO=2 grants D; PRIO=0 grants the port not equal to last_grant.
  - Neither valid: no grant. m_en_o=0, m_we_o=0, last_grant unchanged.
- Ready:
  - x_ready_o = 1 unless the other port is granted this cycle. A non-requesting, non-blocked port sees ready=1.
  - A request transfers when avalid & ready are both high.
  - A losing requester must hold avalid, addr, wdata and wstrb stable until ready.
- Muxing:
  - m_en_o=1 with the granted port's addr, wstrb and wdata driven to the SRAM.
  - m_we_o = granted wstrb.
- last_grant updates on every clock edge where a grant occurs (all PRIO modes; the value is used only in PRIO=0).
- Read (wstrb==0) granted in cycle N:
  - Registered pend_i or pend_d set.
  - Cycle N+1: x_rvalid_o=1 for exactly one cycle; x_rdata_o = m_dout_i.
- Write (wstrb!=0): no rvalid is ever generated.
- Both rdata outputs are driven from m_dout_i continuously and are meaningful only while the matching rvalid is high.
- Throughput:
  - Back-to-back grants allowed every cycle. A new read may be granted in the same cycle an earlier read's rvalid is asserted.
  - A single requester streaming gets 1 request/cycle.
  - Two PRIO=0 requesters streaming alternate I, D, I, D.
- Fairness: under PRIO=0 a held request waits at most 1 cycle. Under PRIO=1/2 the low-priority port may starve; this is the intended behaviour.
- Reset mid-operation: a read granted in the cycle rst_i is high produces no rvalid afterwards. Pending reads are discarded.
- Grant logic is purely combinational from avalid and last_grant. Registered state is limited to last_grant, pend_i, pend_d and the rvalids.

Test Plan:
- Reset, then I reads addr 0x010 (RAM holds 0xDEADBEEF), D idle -> i_ready_o=1 in the same cycle; m_addr_o=0x010; next cycle i_rvalid_o=1, i_rdata_o=0xDEADBEEF; d_rvalid_o stays 0.
- PRIO=0, I and D both read continuously from cycle 0 (I addr 0x1, D addr 0x2) -> grant order I, D, I, D; ready toggles complementarily; each rvalid pulses every other cycle with the correct data.
- D writes 0xA5A5A5A5 to 0x020 with wstrb=4'b0011, then D reads 0x020 (prior content 0x12345678) -> m_we_o=4'b0011 on the write with no rvalid; the read returns 0x1234A5A5 one cycle after its grant.
- PRIO=1, both request for 5 cycles -> I granted all 5 cycles; d_ready_o=0 throughout; D's request is held stable and granted the first cycle I drops avalid.
- Read granted in cycle N with rst_i=1 in cycle N -> no rvalid in cycle N+1; after reset a simultaneous I+D request grants I first.
- Read on I in cycle N and read on D in cycle N+1 -> i_rvalid_o in N+1, d_rvalid_o in N+2; never both high in the same cycle.
